table_controller: RTL and testbench
===================================

TABLE_CONTROLLER -- requirements
Module: table_controller

Interface
REQ-001 Parameter SEED, 16'hACE1, nonzero reset value of the card LFSR.
REQ-002 Parameter DEALER_STAND, 17, dealer stands at hand >= this value (soft or hard).
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 start  in  1  begins a round when sampled high in IDLE; ignored in every other state.
REQ-006 ext_en, ext_cval  in  1, 4  ext_en=1 makes every drawn card come from ext_cval; the LFSR is not used.
REQ-007 p_request  in  1  player card request; level, held until the card is taken.
REQ-008 p_end, p_hand, p_defeat  in  1, 5, 1  player finished, final points (0..31), player bust.
REQ-009 p_begin  out  1  one-cycle round-start pulse to the player.
REQ-010 cval, ready  out  4, 1  card value (2..11, 11 = ace) and card-valid to the player.
REQ-011 dealer_hand  out  5  dealer points.
REQ-012 result, done  out  2, 1  result 00 none, 01 player wins, 10 player loses, 11 push; done high while result is valid.
REQ-013 dbg_state  out  4  current state encoding, for the LEDs.

Function
REQ-014 States: IDLE, BEGIN, SERVE, DRAW_P, ISSUE, DRAW_D, ADD_D, ADJ_D, JUDGE, DONE.
REQ-015 IDLE: start=1 -> BEGIN; dealer_hand, ace count and result cleared on that edge.
REQ-016 BEGIN: p_begin=1 for exactly one cycle, then SERVE.
REQ-017 SERVE: p_end=1 -> (p_defeat=1 ? result=10, DONE : DRAW_D); else p_request=1 -> DRAW_P; else stay. p_end takes priority over p_request.
REQ-018 LFSR: 16-bit Galois, mask 16'hB400, advances every cycle in every state except during reset.
REQ-019 Draw, LFSR mode: r = lfsr[3:0]. r>=13 -> reject and retry next cycle. r=0 -> 11; r=1..8 -> r+1; r=9..12 -> 10.
REQ-020 Draw, ext mode: the card is taken in one cycle. ext_cval 0..1 -> 2; 2..11 -> as given; 12..15 -> 10.
REQ-021 DRAW_P: on an accepted card, latch cval and go to ISSUE.
REQ-022 ISSUE: ready=1 while p_request=1. When p_request falls, ready=0 on the next cycle and the state returns to SERVE.
REQ-023 cval holds its value from the ready rise until the next accepted card, so the player can capture it one cycle after ready.
REQ-024 DRAW_D: an accepted card goes to ADD_D.
REQ-025 ADD_D: dealer_hand += card (5-bit, no overflow: max 16+11=27). Card 11 also increments the soft-ace count (3-bit). Next state is ADJ_D.
REQ-026 ADJ_D, checked in this order:
  - hand>21 and soft>0 -> hand-=10, soft-=1, stay in ADJ_D;
  - hand>21 -> result=01, DONE;
  - hand>=DEALER_STAND -> JUDGE;
  - otherwise -> DRAW_D.
REQ-027 JUDGE: p_hand>dealer_hand -> 01; p_hand<dealer_hand -> 10; equal -> 11. One cycle, then DONE.
REQ-028 DONE: done=1, result held. start=1 -> BEGIN, and result and dealer_hand are cleared on that edge.
REQ-029 A p_request rise while in DRAW_D..DONE is ignored (ready stays 0).

Reset
REQ-030 rst=1 at a clock edge, from any state:
  - state -> IDLE, lfsr -> SEED;
  - p_begin, ready, done -> 0;
  - cval, dealer_hand, soft count, result -> 0.
REQ-031 Reset mid-round abandons the round; the first post-reset start behaves as from power-up.

Structure
REQ-032 A shared package holds the state encoding, the result codes (RES_NONE/WIN/LOSE/PUSH), ACE_VAL=11 and LFSR_MASK.
REQ-033 The LFSR and card mapping form one sub-module, card_source: inputs clk, rst, ext_en, ext_cval; outputs card, card_ok.

Verification
REQ-034 Player bust: ext_en=1, ext_cval=10. Model the player taking 10,10,10 so p_hand=30 and p_defeat=1, then p_end=1.
  - Expect result=10 and done=1 one cycle after SERVE samples p_end.
  - Expect no dealer draw; dealer_hand stays 0.
REQ-035 Dealer soft ace: ext cards 11 then 6. Expect dealer_hand 11 -> 17, then stand. With p_hand=18, expect result=01.
REQ-036 Ace demotion: ext cards 11,5,9. Expect dealer_hand 11 -> 16 -> 25 -> 15 (soft 0), then another draw; ext 10 -> 25 -> bust, result=01.
REQ-037 Push: dealer cards 10,10 and p_hand=20. Expect result=11 exactly two cycles after the dealer_hand=20 update.
REQ-038 Handshake: hold p_request for 3 cycles after ready rises. Expect:
  - ready stays high for the full hold and falls one cycle after p_request falls;
  - cval is constant throughout;
  - start pulses during the round have no effect.
REQ-039 Reset in ISSUE, and LFSR mode with SEED=16'h0001:
  - the reset cycle clears ready, cval, result and dealer_hand, and the state reads IDLE;
  - over 1000 draws every card is in 2..11, and no card is issued on a cycle where lfsr[3:0]>=13.

Source files
------------

// File: rtl/table_controller_pkg.sv
// Shared definitions for the blackjack table controller: state encoding,
// result codes and the card-mapping helpers used by the card source.
package table_controller_pkg;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_BEGIN  = 4'd1,
    S_SERVE  = 4'd2,
    S_DRAW_P = 4'd3,
    S_ISSUE  = 4'd4,
    S_DRAW_D = 4'd5,
    S_ADD_D  = 4'd6,
    S_ADJ_D  = 4'd7,
    S_JUDGE  = 4'd8,
    S_DONE   = 4'd9
  } state_e;

  localparam logic [1:0]  RES_NONE  = 2'b00;
  localparam logic [1:0]  RES_WIN   = 2'b01;
  localparam logic [1:0]  RES_LOSE  = 2'b10;
  localparam logic [1:0]  RES_PUSH  = 2'b11;
  localparam logic [3:0]  ACE_VAL   = 4'd11;
  localparam logic [15:0] LFSR_MASK = 16'hB400;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    if (s[0]) begin
      return {1'b0, s[15:1]} ^ LFSR_MASK;
    end else begin
      return {1'b0, s[15:1]};
    end
  endfunction

  // Values 13..15 are rejected by the caller; the zero return is never used.
  function automatic logic [3:0] map_lfsr(input logic [3:0] r);
    case (r)
      4'd0:                                           return ACE_VAL;
      4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8: return r + 4'd1;
      4'd9, 4'd10, 4'd11, 4'd12:                      return 4'd10;
      default:                                        return 4'd0;
    endcase
  endfunction

  function automatic logic [3:0] map_ext(input logic [3:0] v);
    case (v)
      4'd0, 4'd1:                  return 4'd2;
      4'd12, 4'd13, 4'd14, 4'd15:  return 4'd10;
      default:                     return v;
    endcase
  endfunction

endpackage

// File: rtl/table_controller_card_source.sv
// Card generator: free-running Galois LFSR with rejection sampling, or an
// externally supplied card value when ext_en is set.
module card_source
  import table_controller_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ext_en,
  input  logic [3:0] ext_cval,
  output logic [3:0] card,
  output logic       card_ok
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  // LFSR next value, advancing every cycle
  always_comb begin
    lfsr_d = lfsr_step(lfsr_q);
  end

  // LFSR register
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  // Card selection and validity
  always_comb begin
    card    = 4'd0;
    card_ok = 1'b0;
    if (ext_en) begin
      card    = map_ext(ext_cval);
      card_ok = 1'b1;
    end else begin
      card    = map_lfsr(lfsr_q[3:0]);
      card_ok = (lfsr_q[3:0] < 4'd13);
    end
  end

endmodule

// File: rtl/table_controller.sv
// Blackjack table controller: deals cards to an external player over a
// request/ready handshake, then plays the dealer hand and judges the round.
module table_controller
  import table_controller_pkg::*;
#(
  parameter logic [15:0] SEED         = 16'hACE1,
  parameter int unsigned DEALER_STAND = 17
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       ext_en,
  input  logic [3:0] ext_cval,
  input  logic       p_request,
  input  logic       p_end,
  input  logic [4:0] p_hand,
  input  logic       p_defeat,
  output logic       p_begin,
  output logic [3:0] cval,
  output logic       ready,
  output logic [4:0] dealer_hand,
  output logic [1:0] result,
  output logic       done,
  output logic [3:0] dbg_state
);

  localparam logic [4:0] STAND_HAND = 5'(DEALER_STAND);

  state_e     state_q, state_d;
  logic [4:0] dealer_hand_q, dealer_hand_d;
  logic [2:0] soft_q, soft_d;
  logic [1:0] result_q, result_d;
  logic [3:0] cval_q, cval_d;
  logic       p_begin_q, p_begin_d;
  logic       ready_q, ready_d;
  logic       done_q, done_d;
  logic [3:0] card_s;
  logic       card_ok_s;
  logic       bust_s;

  card_source #(.SEED(SEED)) u_card_source (
    .clk      (clk),
    .rst      (rst),
    .ext_en   (ext_en),
    .ext_cval (ext_cval),
    .card     (card_s),
    .card_ok  (card_ok_s)
  );

  assign bust_s = (dealer_hand_q > 5'd21);

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      dealer_hand_q <= 5'd0;
      soft_q        <= 3'd0;
      result_q      <= RES_NONE;
      cval_q        <= 4'd0;
      p_begin_q     <= 1'b0;
      ready_q       <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      dealer_hand_q <= dealer_hand_d;
      soft_q        <= soft_d;
      result_q      <= result_d;
      cval_q        <= cval_d;
      p_begin_q     <= p_begin_d;
      ready_q       <= ready_d;
      done_q        <= done_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_BEGIN; else state_d = S_IDLE;
      S_BEGIN:  state_d = S_SERVE;
      S_SERVE: begin
        if (p_end) begin
          if (p_defeat) state_d = S_DONE; else state_d = S_DRAW_D;
        end else if (p_request) begin
          state_d = S_DRAW_P;
        end else begin
          state_d = S_SERVE;
        end
      end
      S_DRAW_P: if (card_ok_s) state_d = S_ISSUE; else state_d = S_DRAW_P;
      S_ISSUE:  if (!p_request) state_d = S_SERVE; else state_d = S_ISSUE;
      S_DRAW_D: if (card_ok_s) state_d = S_ADD_D; else state_d = S_DRAW_D;
      S_ADD_D:  state_d = S_ADJ_D;
      S_ADJ_D: begin
        if (bust_s && (soft_q != 3'd0)) begin
          state_d = S_ADJ_D;
        end else if (bust_s) begin
          state_d = S_DONE;
        end else if (dealer_hand_q >= STAND_HAND) begin
          state_d = S_JUDGE;
        end else begin
          state_d = S_DRAW_D;
        end
      end
      S_JUDGE:  state_d = S_DONE;
      S_DONE:   if (start) state_d = S_BEGIN; else state_d = S_DONE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Datapath updates and registered output flags
  always_comb begin
    dealer_hand_d = dealer_hand_q;
    soft_d        = soft_q;
    result_d      = result_q;
    cval_d        = cval_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          dealer_hand_d = 5'd0;
          soft_d        = 3'd0;
          result_d      = RES_NONE;
        end else begin
          result_d = result_q;
        end
      end
      S_SERVE: begin
        if (p_end && p_defeat) result_d = RES_LOSE; else result_d = result_q;
      end
      S_DRAW_P, S_DRAW_D: begin
        if (card_ok_s) cval_d = card_s; else cval_d = cval_q;
      end
      S_ADD_D: begin
        dealer_hand_d = dealer_hand_q + {1'b0, cval_q};
        if (cval_q == ACE_VAL) soft_d = soft_q + 3'd1; else soft_d = soft_q;
      end
      // A soft ace is demoted from 11 to 1 before a bust is declared
      S_ADJ_D: begin
        if (bust_s && (soft_q != 3'd0)) begin
          dealer_hand_d = dealer_hand_q - 5'd10;
          soft_d        = soft_q - 3'd1;
        end else if (bust_s) begin
          result_d = RES_WIN;
        end else begin
          result_d = result_q;
        end
      end
      S_JUDGE: begin
        if (p_hand > dealer_hand_q) begin
          result_d = RES_WIN;
        end else if (p_hand < dealer_hand_q) begin
          result_d = RES_LOSE;
        end else begin
          result_d = RES_PUSH;
        end
      end
      default: result_d = result_q;
    endcase
    p_begin_d = (state_d == S_BEGIN);
    ready_d   = (state_d == S_ISSUE);
    done_d    = (state_d == S_DONE);
  end

  assign p_begin     = p_begin_q;
  assign cval        = cval_q;
  assign ready       = ready_q;
  assign dealer_hand = dealer_hand_q;
  assign result      = result_q;
  assign done        = done_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_table_controller.sv
// Directed self-checking bench for table_controller: player bust, dealer
// soft-ace handling, push timing, handshake, resets and LFSR card quality.
module tb_table_controller;
  import table_controller_pkg::*;

  logic       clk = 1'b0;
  logic       rst, start, ext_en, p_request, p_end, p_defeat;
  logic [3:0] ext_cval;
  logic [4:0] p_hand;
  logic       p_begin, ready, done;
  logic [3:0] cval, dbg_state;
  logic [4:0] dealer_hand;
  logic [1:0] result;

  int checks   = 0;
  int failures = 0;

  logic [15:0] m_lfsr;
  logic [3:0]  cards[4];
  logic [4:0]  hist[$];
  int          t20, tres;

  always #5 clk = ~clk;

  table_controller #(.SEED(16'h0001), .DEALER_STAND(17)) dut (
    .clk(clk), .rst(rst), .start(start), .ext_en(ext_en), .ext_cval(ext_cval),
    .p_request(p_request), .p_end(p_end), .p_hand(p_hand), .p_defeat(p_defeat),
    .p_begin(p_begin), .cval(cval), .ready(ready), .dealer_hand(dealer_hand),
    .result(result), .done(done), .dbg_state(dbg_state)
  );

  // Reference LFSR, advancing in lockstep with the card source
  always @(posedge clk) begin
    if (rst) m_lfsr <= 16'h0001;
    else     m_lfsr <= m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
  end

  function automatic logic [3:0] exp_card(input logic [3:0] r);
    if (r == 4'd0)      return 4'd11;
    else if (r <= 4'd8) return r + 4'd1;
    else                return 4'd10;
  endfunction

  task automatic start_round();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
  endtask

  task automatic player_card(input logic [3:0] v, input int hold, output logic [3:0] got);
    bit seen = 1'b0;
    ext_cval  = v;
    p_request = 1'b1;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (ready) seen = 1'b1;
    end
    if (!seen) begin
      checks++; failures++;
      $display("FAIL player_card_timeout: ready=%0b required=1", ready);
    end
    got = cval;
    repeat (hold) @(negedge clk);
    p_request = 1'b0;
    @(negedge clk);
  endtask

  task automatic dealer_phase(input logic [3:0] a, b, c, d, input logic [4:0] ph);
    int idx = 0;
    logic [4:0] last;
    cards[0] = a; cards[1] = b; cards[2] = c; cards[3] = d;
    hist.delete();
    last = dealer_hand; t20 = -1; tres = -1;
    p_hand = ph; p_defeat = 1'b0; p_end = 1'b1;
    for (int cyc = 0; cyc < 80; cyc++) begin
      @(negedge clk);
      p_end = 1'b0;
      if (dealer_hand != last) begin
        hist.push_back(dealer_hand);
        last = dealer_hand;
        if (dealer_hand == 5'd20 && t20 < 0) t20 = cyc;
      end
      if (result != RES_NONE && tres < 0) tres = cyc;
      if (done) break;
      if (dbg_state == S_DRAW_D) begin
        ext_cval = cards[idx];
        if (idx < 3) idx++;
      end
    end
    if (!done) begin
      checks++; failures++;
      $display("FAIL dealer_timeout: done=%0b required=1", done);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; ext_en = 1'b1; ext_cval = 4'd0;
    p_request = 1'b0; p_end = 1'b0; p_hand = 5'd0; p_defeat = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (dbg_state !== 4'd0) begin failures++; $display("FAIL reset_state: got=%0d exp=0", dbg_state); end
    checks++; if ({p_begin, ready, done} !== 3'b000) begin failures++; $display("FAIL reset_flags: got=%b exp=000", {p_begin, ready, done}); end
    checks++; if (cval !== 4'd0) begin failures++; $display("FAIL reset_cval: got=%0d exp=0", cval); end
    checks++; if (dealer_hand !== 5'd0 || result !== 2'b00) begin failures++; $display("FAIL reset_hand_result: got=%0d/%b exp=0/00", dealer_hand, result); end
    rst = 1'b0;
  endtask

  task automatic test_player_bust();
    logic [3:0] c;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    checks++; if (p_begin !== 1'b1 || dbg_state !== 4'(S_BEGIN)) begin failures++; $display("FAIL begin_pulse: got=%0b/%0d exp=1/1", p_begin, dbg_state); end
    @(negedge clk);
    checks++; if (p_begin !== 1'b0 || dbg_state !== 4'(S_SERVE)) begin failures++; $display("FAIL begin_end: got=%0b/%0d exp=0/2", p_begin, dbg_state); end
    for (int i = 0; i < 3; i++) begin
      player_card(4'd10, 0, c);
      checks++; if (c !== 4'd10) begin failures++; $display("FAIL bust_card%0d: got=%0d exp=10", i, c); end
    end
    p_hand = 5'd30; p_defeat = 1'b1; p_end = 1'b1;
    @(negedge clk);
    p_end = 1'b0;
    checks++; if (result !== RES_LOSE || done !== 1'b1) begin failures++; $display("FAIL bust_result: got=%b/%0b exp=10/1", result, done); end
    p_request = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (ready !== 1'b0 || dbg_state !== 4'(S_DONE)) begin failures++; $display("FAIL done_ignores_req: got=%0b/%0d exp=0/9", ready, dbg_state); end
    checks++; if (dealer_hand !== 5'd0) begin failures++; $display("FAIL bust_no_dealer: got=%0d exp=0", dealer_hand); end
    p_request = 1'b0; p_defeat = 1'b0;
  endtask

  task automatic test_soft_ace();
    start_round();
    dealer_phase(4'd11, 4'd6, 4'd0, 4'd0, 5'd18);
    checks++; if (hist.size() != 2 || hist[0] !== 5'd11 || hist[1] !== 5'd17) begin failures++; $display("FAIL soft_ace_hist: got_len=%0d exp_len=2 (11,17)", hist.size()); end
    checks++; if (result !== RES_WIN || done !== 1'b1) begin failures++; $display("FAIL soft_ace_result: got=%b exp=01", result); end
  endtask

  task automatic test_ace_demotion();
    start_round();
    dealer_phase(4'd11, 4'd5, 4'd9, 4'd10, 5'd20);
    checks++;
    if (hist.size() != 5 || hist[0] !== 5'd11 || hist[1] !== 5'd16 || hist[2] !== 5'd25 ||
        hist[3] !== 5'd15 || hist[4] !== 5'd25) begin
      failures++; $display("FAIL demotion_hist: got_len=%0d exp_len=5 (11,16,25,15,25)", hist.size());
    end
    checks++; if (result !== RES_WIN) begin failures++; $display("FAIL demotion_result: got=%b exp=01", result); end
  endtask

  task automatic test_push();
    start_round();
    checks++; if (result !== RES_NONE || dealer_hand !== 5'd0) begin failures++; $display("FAIL restart_clear: got=%b/%0d exp=00/0", result, dealer_hand); end
    dealer_phase(4'd10, 4'd10, 4'd0, 4'd0, 5'd20);
    checks++; if (hist.size() != 2 || hist[1] !== 5'd20) begin failures++; $display("FAIL push_hist: got_len=%0d exp_len=2 (10,20)", hist.size()); end
    checks++; if (result !== RES_PUSH) begin failures++; $display("FAIL push_result: got=%b exp=11", result); end
    checks++; if (tres - t20 != 2) begin failures++; $display("FAIL push_latency: got=%0d exp=2", tres - t20); end
  endtask

  task automatic test_handshake();
    logic [3:0] c;
    logic [3:0] v_tab[3];
    logic [3:0] e_tab[3];
    bit seen = 1'b0;
    v_tab[0] = 4'd13; v_tab[1] = 4'd0; v_tab[2] = 4'd11;
    e_tab[0] = 4'd10; e_tab[1] = 4'd2; e_tab[2] = 4'd11;
    start_round();
    ext_cval = 4'd1; p_request = 1'b1;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (ready) seen = 1'b1;
    end
    checks++; if (!seen || cval !== 4'd2) begin failures++; $display("FAIL hs_first: got=%0b/%0d exp=1/2", ready, cval); end
    for (int k = 0; k < 3; k++) begin
      start = (k == 1);
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (ready !== 1'b1 || cval !== 4'd2 || dbg_state !== 4'(S_ISSUE)) begin
        failures++; $display("FAIL hs_hold%0d: got=%0b/%0d/%0d exp=1/2/4", k, ready, cval, dbg_state);
      end
    end
    p_request = 1'b0;
    @(negedge clk);
    checks++; if (ready !== 1'b0 || dbg_state !== 4'(S_SERVE) || cval !== 4'd2) begin failures++; $display("FAIL hs_release: got=%0b/%0d/%0d exp=0/2/2", ready, dbg_state, cval); end
    for (int i = 0; i < 3; i++) begin
      player_card(v_tab[i], 1, c);
      checks++; if (c !== e_tab[i]) begin failures++; $display("FAIL ext_map%0d: got=%0d exp=%0d", i, c, e_tab[i]); end
    end
  endtask

  task automatic test_reset_mid_round();
    bit seen = 1'b0;
    p_defeat = 1'b1; p_hand = 5'd25; p_end = 1'b1;
    @(negedge clk); p_end = 1'b0; p_defeat = 1'b0;
    dealer_phase(4'd10, 4'd9, 4'd0, 4'd0, 5'd19);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (result !== 2'b00 || dealer_hand !== 5'd0 || done !== 1'b0) begin failures++; $display("FAIL rst_done_clear: got=%b/%0d/%0b exp=00/0/0", result, dealer_hand, done); end
    start_round();
    ext_cval = 4'd5; p_request = 1'b1;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (ready) seen = 1'b1;
    end
    checks++; if (!seen || cval !== 4'd5) begin failures++; $display("FAIL rst_issue_pre: got=%0b/%0d exp=1/5", ready, cval); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; p_request = 1'b0;
    checks++; if (ready !== 1'b0 || cval !== 4'd0 || dbg_state !== 4'd0) begin failures++; $display("FAIL rst_issue: got=%0b/%0d/%0d exp=0/0/0", ready, cval, dbg_state); end
  endtask

  task automatic test_lfsr_draws();
    bit         got, prev_drawp;
    logic [3:0] prev_r;
    ext_en = 1'b0;
    start_round();
    for (int d = 0; d < 1000; d++) begin
      p_request = 1'b1; got = 1'b0; prev_drawp = 1'b0; prev_r = 4'd0;
      for (int cyc = 0; cyc < 64 && !got; cyc++) begin
        @(negedge clk);
        if (prev_drawp) begin
          checks++;
          if (prev_r < 4'd13) begin
            if (dbg_state !== 4'(S_ISSUE) || ready !== 1'b1 || cval !== exp_card(prev_r)) begin
              failures++; $display("FAIL lfsr_accept d=%0d r=%0d: got=%0d/%0d exp=4/%0d", d, prev_r, dbg_state, cval, exp_card(prev_r));
            end
            got = 1'b1;
          end else if (dbg_state !== 4'(S_DRAW_P) || ready !== 1'b0) begin
            failures++; $display("FAIL lfsr_reject d=%0d r=%0d: got=%0d/%0b exp=3/0", d, prev_r, dbg_state, ready);
          end
        end
        prev_drawp = (dbg_state == 4'(S_DRAW_P));
        prev_r     = m_lfsr[3:0];
      end
      checks++;
      if (!got || cval < 4'd2 || cval > 4'd11) begin
        failures++; $display("FAIL lfsr_card d=%0d: got=%0d exp=2..11", d, cval);
      end
      p_request = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_player_bust();
    test_soft_ace();
    test_ace_demotion();
    test_push();
    test_handshake();
    test_reset_mid_round();
    test_lfsr_draws();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
